// File: rtl/sccb_config_ctrl.sv
// rtl/sccb_config_ctrl.sv - SCCB write-only master that walks a register table to configure the OV2640
module sccb_config_ctrl #(
  parameter int         CLK_FREQ_HZ  = 24000000,
  parameter int         SCCB_FREQ_HZ = 100000,
  parameter logic [7:0] DEV_ID       = 8'h60,
  parameter int         TABLE_AW     = 8,
  parameter int         PWRUP_CYCLES = 24000,
  parameter int         SWRST_CYCLES = 24000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [TABLE_AW:0]   tbl_len,
  output logic [TABLE_AW-1:0] tbl_addr,
  input  logic [15:0]         tbl_data,
  output logic                sccb_scl,
  output logic                sio_d_oe,
  input  logic                sio_d_in,
  output logic                busy,
  output logic                done,
  output logic                ack_err
);

  localparam int          Q_RAW      = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int          Q          = (Q_RAW < 1) ? 1 : Q_RAW;
  localparam logic [15:0] Q_LAST     = 16'(Q - 1);
  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYCLES - 1);
  localparam logic [31:0] SWRST_LAST = 32'(SWRST_CYCLES - 1);
  localparam logic [TABLE_AW:0]   LEN_ONE  = (TABLE_AW+1)'(1);
  localparam logic [TABLE_AW-1:0] ADDR_ONE = TABLE_AW'(1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_PWRUP = 4'd1;
  localparam logic [3:0] S_FETCH = 4'd2;
  localparam logic [3:0] S_LATCH = 4'd3;
  localparam logic [3:0] S_START = 4'd4;
  localparam logic [3:0] S_BITS  = 4'd5;
  localparam logic [3:0] S_STOP  = 4'd6;
  localparam logic [3:0] S_GAP   = 4'd7;
  localparam logic [3:0] S_SWRST = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic [3:0]        state;
  logic [15:0]       q_cnt;
  logic [1:0]        quarter;
  logic [4:0]        slot;
  logic [31:0]       wait_cnt;
  logic [15:0]       entry;
  logic [TABLE_AW:0] len_q;

  logic        q_tick;
  logic        phase_end;
  logic        timed;
  logic [26:0] frame;
  logic        frame_bit;
  logic        ack_slot;
  logic        swrst_entry;
  logic        last_entry;
  logic        scl_nxt;
  logic        oe_nxt;

  // Frame of 27 slots: ID, X, sub-address, X, data, X; X slots release the line (bit = 1).
  assign frame       = {DEV_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
  assign frame_bit   = frame[5'd26 - slot];
  assign ack_slot    = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  assign q_tick      = (q_cnt == Q_LAST);
  assign phase_end   = q_tick && (quarter == 2'd3);
  assign timed       = state inside {S_START, S_BITS, S_STOP, S_GAP};
  assign swrst_entry = (entry[15:8] == 8'h12) && entry[7];
  assign last_entry  = (({1'b0, tbl_addr} + LEN_ONE) == len_q);

  // Bus levels wanted for the current state/quarter; registered below so the pads never glitch.
  always_comb begin
    scl_nxt = 1'b1;
    oe_nxt  = 1'b0;
    case (state)
      S_START: begin
        scl_nxt = (quarter != 2'd3);
        oe_nxt  = quarter[1];
      end
      S_BITS: begin
        scl_nxt = (quarter == 2'd1) || (quarter == 2'd2);
        oe_nxt  = ~frame_bit;
      end
      S_STOP: begin
        scl_nxt = (quarter != 2'd0);
        oe_nxt  = ~quarter[1];
      end
      default: begin
        scl_nxt = 1'b1;
        oe_nxt  = 1'b0;
      end
    endcase
  end

  // Pad registers; reset leaves the bus released with SCL high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sccb_scl <= 1'b1;
      sio_d_oe <= 1'b0;
    end else begin
      sccb_scl <= scl_nxt;
      sio_d_oe <= oe_nxt;
    end
  end

  // Quarter-bit timebase; restarts from zero whenever a timed state is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_cnt   <= 16'd0;
      quarter <= 2'd0;
    end else if (timed) begin
      if (q_tick) begin
        q_cnt   <= 16'd0;
        quarter <= quarter + 2'd1;
      end else begin
        q_cnt <= q_cnt + 16'd1;
      end
    end else begin
      q_cnt   <= 16'd0;
      quarter <= 2'd0;
    end
  end

  // Run sequencer: power-up wait, per-entry fetch/latch/write, optional soft-reset wait, completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      slot     <= 5'd0;
      wait_cnt <= 32'd0;
      entry    <= 16'd0;
      len_q    <= '0;
      tbl_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            tbl_addr <= '0;
            len_q    <= tbl_len;
            wait_cnt <= 32'd0;
            state    <= S_PWRUP;
          end
        end
        S_PWRUP: begin
          if (wait_cnt == PWRUP_LAST) begin
            wait_cnt <= 32'd0;
            state    <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        // An empty table is resolved here, so it finishes without touching the bus.
        S_FETCH: begin
          if (len_q == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          entry <= tbl_data;
          state <= S_START;
        end
        S_START: begin
          if (phase_end) begin
            slot  <= 5'd0;
            state <= S_BITS;
          end
        end
        S_BITS: begin
          if (q_tick && (quarter == 2'd2) && ack_slot && sio_d_in) begin
            ack_err <= 1'b1;
          end
          if (phase_end) begin
            if (slot == 5'd26) begin
              state <= S_STOP;
            end else begin
              slot <= slot + 5'd1;
            end
          end
        end
        S_STOP: begin
          if (phase_end) begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (phase_end) begin
            if (swrst_entry) begin
              wait_cnt <= 32'd0;
              state    <= S_SWRST;
            end else if (last_entry) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              tbl_addr <= tbl_addr + ADDR_ONE;
              state    <= S_FETCH;
            end
          end
        end
        S_SWRST: begin
          if (wait_cnt == SWRST_LAST) begin
            wait_cnt <= 32'd0;
            if (last_entry) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              tbl_addr <= tbl_addr + ADDR_ONE;
              state    <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_ctrl.sv
// tb/tb_sccb_config_ctrl.sv - directed self-checking bench for sccb_config_ctrl with an SCCB slave model
module tb_sccb_config_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  tbl_len;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data = 16'h0000;
  logic        sccb_scl;
  logic        sio_d_oe;
  logic        sio_d_in;
  logic        busy;
  logic        done;
  logic        ack_err;

  logic        pull = 1'b0;
  logic [15:0] rom [0:255];
  int          nack_num;
  int          clr_gen = 0;

  logic [7:0]  bytes [$];
  int          start_t [$];
  int          n_start = 0;
  int          n_stop = 0;
  logic        scl_low = 1'b0;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;
  int lat;

  always #5 clk = ~clk;

  // Open-drain SIO_D: low if the master or the slave pulls it.
  assign sio_d_in = ~(sio_d_oe | pull);

  sccb_config_ctrl #(
    .CLK_FREQ_HZ (400),
    .SCCB_FREQ_HZ(100),
    .DEV_ID      (8'h60),
    .TABLE_AW    (8),
    .PWRUP_CYCLES(10),
    .SWRST_CYCLES(50)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .tbl_len (tbl_len),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .sccb_scl(sccb_scl),
    .sio_d_oe(sio_d_oe),
    .sio_d_in(sio_d_in),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err)
  );

  // Table ROM plus SCCB slave: decodes START/STOP/bytes, ACKs every byte except byte number nack_num.
  int       cyc = 0;
  int       seen_gen = 0;
  int       bitcnt = 0;
  int       byte_num = 0;
  logic     prev_scl = 1'b1;
  logic     prev_sda = 1'b1;
  logic     scl_s;
  logic     sda_s;
  logic [7:0] shreg = 8'h00;
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    tbl_data = rom[tbl_addr];
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      bytes.delete();
      start_t.delete();
      n_start = 0;
      n_stop = 0;
      bitcnt = 0;
      byte_num = 0;
      pull = 1'b0;
      scl_low = 1'b0;
      prev_scl = sccb_scl;
      prev_sda = ~sio_d_oe;
    end else begin
      scl_s = sccb_scl;
      sda_s = ~(sio_d_oe | pull);
      if (!scl_s) scl_low = 1'b1;
      if (prev_scl && scl_s && prev_sda && !sda_s) begin
        n_start = n_start + 1;
        start_t.push_back(cyc);
        bitcnt = 0;
      end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
        n_stop = n_stop + 1;
      end else if (!prev_scl && scl_s) begin
        if (bitcnt < 8) begin
          shreg = {shreg[6:0], sda_s};
          bitcnt = bitcnt + 1;
          if (bitcnt == 8) bytes.push_back(shreg);
        end
      end else if (prev_scl && !scl_s) begin
        if (bitcnt == 8) begin
          pull = (byte_num != nack_num);
          byte_num = byte_num + 1;
          bitcnt = 9;
        end else if (bitcnt == 9) begin
          pull = 1'b0;
          bitcnt = 0;
        end
      end
      prev_scl = scl_s;
      prev_sda = ~(sio_d_oe | pull);
    end
  end

  function automatic logic [7:0] getb(input int i);
    if (i < bytes.size()) return bytes[i];
    return 8'hxx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    clr_gen++;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int l);
    l = 0;
    while (!done && l < budget) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    tbl_len  = 9'd0;
    nack_num = -1;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_scl", sccb_scl, 1);
    chk("rst_oe", sio_d_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single entry 3A04, slave ACKs
    rom[0] = 16'h3A04;
    tbl_len = 9'd1;
    clear_model();
    pulse_start();
    chk("t1_busy_rise", busy, 1);
    chk("t1_done_low", done, 0);
    wait_done(400, lat);
    chk("t1_latency", lat, 132);
    chk("t1_nbytes", bytes.size(), 3);
    chk("t1_byte0", getb(0), 8'h60);
    chk("t1_byte1", getb(1), 8'h3A);
    chk("t1_byte2", getb(2), 8'h04);
    chk("t1_nstart", n_start, 1);
    chk("t1_nstop", n_stop, 1);
    chk("t1_ack_err", ack_err, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_tbl_addr", tbl_addr, 0);

    // Three entries with a soft reset on the second
    rom[0] = 16'hFF01;
    rom[1] = 16'h1280;
    rom[2] = 16'h1101;
    tbl_len = 9'd3;
    clear_model();
    pulse_start();
    wait_done(800, lat);
    chk("t2_latency", lat, 426);
    chk("t2_nbytes", bytes.size(), 9);
    chk("t2_e0_reg", getb(1), 8'hFF);
    chk("t2_e0_val", getb(2), 8'h01);
    chk("t2_e1_id", getb(3), 8'h60);
    chk("t2_e1_reg", getb(4), 8'h12);
    chk("t2_e1_val", getb(5), 8'h80);
    chk("t2_e2_reg", getb(7), 8'h11);
    chk("t2_e2_val", getb(8), 8'h01);
    chk("t2_nstart", start_t.size(), 3);
    if (start_t.size() == 3) begin
      chk("t2_gap01", start_t[1] - start_t[0], 122);
      chk("t2_gap12", start_t[2] - start_t[1], 172);
    end
    chk("t2_nstop", n_stop, 3);
    chk("t2_tbl_addr", tbl_addr, 2);
    chk("t2_ack_err", ack_err, 0);

    // NACK on the sub-address byte of entry 0 of 2
    rom[0] = 16'h3A04;
    rom[1] = 16'h1101;
    tbl_len = 9'd2;
    nack_num = 1;
    clear_model();
    pulse_start();
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("t3_ack_err_mid", ack_err, 1);
    chk("t3_busy_mid", busy, 1);
    while (!done && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    chk("t3_latency", lat, 254);
    chk("t3_ack_err_end", ack_err, 1);
    chk("t3_done", done, 1);
    chk("t3_e1_id", getb(3), 8'h60);
    chk("t3_e1_reg", getb(4), 8'h11);
    chk("t3_e1_val", getb(5), 8'h01);
    chk("t3_nstop", n_stop, 2);

    // Empty table; the new start also clears ack_err
    nack_num = -1;
    tbl_len = 9'd0;
    clear_model();
    pulse_start();
    chk("t4_ack_err_clr", ack_err, 0);
    chk("t4_done_clr", done, 0);
    chk("t4_busy", busy, 1);
    wait_done(100, lat);
    chk("t4_latency", lat, 11);
    chk("t4_scl_low_seen", scl_low, 0);
    chk("t4_nstart", n_start, 0);

    // Second start pulse mid-run is ignored
    rom[0] = 16'h3A04;
    tbl_len = 9'd1;
    clear_model();
    pulse_start();
    lat = 0;
    while (!done && lat < 400) begin
      if (lat == 40) begin
        start = 1'b1;
        tbl_len = 9'd2;
      end else begin
        start = 1'b0;
        tbl_len = 9'd1;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    tbl_len = 9'd1;
    chk("t5_latency", lat, 132);
    chk("t5_nstart", n_start, 1);
    chk("t5_nstop", n_stop, 1);

    // Reset during bit slot 5, then a full rerun from index 0
    rom[0] = 16'h3A04;
    rom[1] = 16'h1101;
    tbl_len = 9'd2;
    clear_model();
    pulse_start();
    lat = 0;
    while (lat < 37) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_scl", sccb_scl, 1);
    chk("t6_rst_oe", sio_d_oe, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tbl_addr", tbl_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    pulse_start();
    wait_done(600, lat);
    chk("t6_latency", lat, 254);
    chk("t6_nbytes", bytes.size(), 6);
    chk("t6_e0_reg", getb(1), 8'h3A);
    chk("t6_e0_val", getb(2), 8'h04);
    chk("t6_e1_reg", getb(4), 8'h11);
    chk("t6_e1_val", getb(5), 8'h01);
    chk("t6_nstart", n_start, 2);
    chk("t6_ack_err", ack_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
